bankroll_ctrl: RTL and testbench

Round-level controller for the betting datapath of the Blackjack FPGA. It owns the player balance register and drives the bet register's `bet_lock` and `refresh` inputs. It accepts a finished hand outcome from the game FSM and settles the stake into the balance. It sits between the game FSM (deal and outcome) and the bet register (`bet` in, lock and refresh out), and feeds the balance display.

---
 rtl/bj_pkg.sv | 25 ++
 rtl/bankroll_ctrl_payout_calc.sv | 54 +++++
 rtl/bankroll_ctrl.sv | 140 ++++++++++++++
 tb/tb_bankroll_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// ---------------------------------------------------------------------------
// bj_pkg -- shared types and constants for the Blackjack betting datapath.
//   state_t  : round-level controller states
//   OUT_*    : hand outcome codes delivered by the game FSM
//   BAL_MAX  : saturation ceiling of the default 10-bit balance
// ---------------------------------------------------------------------------
package bj_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_BETTING = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_BROKE   = 3'd4
  } state_t;

  localparam logic [1:0] OUT_LOSE = 2'b00;
  localparam logic [1:0] OUT_PUSH = 2'b01;
  localparam logic [1:0] OUT_WIN  = 2'b10;
  localparam logic [1:0] OUT_BJ   = 2'b11;

  localparam int         BAL_W_DEFAULT = 10;
  localparam logic [9:0] BAL_MAX       = 10'd1023;

endpackage

// File: rtl/bankroll_ctrl_payout_calc.sv
// ---------------------------------------------------------------------------
// payout_calc -- combinational settlement of a finished hand.
// Adds the credit for the hand outcome to the (already debited) balance and
// saturates the result at 2^BAL_W - 1.
//   balance_i     : balance after the stake was taken
//   stake_i       : stake committed for this hand
//   outcome_i     : OUT_LOSE / OUT_PUSH / OUT_WIN / OUT_BJ
//   new_balance_o : saturated settled balance
// Build option: BJ_NATURAL_PAYOUT_EN pays a natural blackjack 3:2
// (2*stake + floor(stake/2)); without it a natural is paid as a plain win.
// ---------------------------------------------------------------------------
module payout_calc
  import bj_pkg::*;
#(
  parameter int BAL_W = 10
) (
  input  logic [BAL_W-1:0] balance_i,
  input  logic [BAL_W-1:0] stake_i,
  input  logic [1:0]       outcome_i,
  output logic [BAL_W-1:0] new_balance_o
);

  // Two guard bits: balance + 2.5*stake never exceeds 4x the balance range.
  localparam logic [BAL_W+1:0] SAT = {2'b00, {BAL_W{1'b1}}};

  logic [BAL_W+1:0] stake_x;
  logic [BAL_W+1:0] credit;
  logic [BAL_W+1:0] sum;

  assign stake_x = {2'b00, stake_i};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    credit = '0;
    unique case (outcome_i)
      OUT_LOSE: credit = '0;
      OUT_PUSH: credit = stake_x;
      OUT_WIN:  credit = stake_x << 1;
      OUT_BJ: begin
`ifdef BJ_NATURAL_PAYOUT_EN
        credit = (stake_x << 1) + (stake_x >> 1);
`else
        credit = stake_x << 1;
`endif
      end
      default:  credit = '0;
    endcase
  end

  assign sum           = {2'b00, balance_i} + credit;
  assign new_balance_o = (sum > SAT) ? {BAL_W{1'b1}} : sum[BAL_W-1:0];

endmodule

// File: rtl/bankroll_ctrl.sv
// ---------------------------------------------------------------------------
// bankroll_ctrl -- round-level controller of the Blackjack betting datapath.
// Owns the player balance, locks/refreshes the bet register and settles each
// finished hand into the balance.
//   clk, reset     : clock; synchronous active-high reset (wins over all)
//   deal           : request to lock the current bet and start a hand
//   bet            : current bet register value
//   outcome_valid  : hand-finished strobe; outcome = 00 lose/01 push/10 win/11 bj
//   new_game       : reload the balance after a bust-out
//   balance        : player bankroll
//   bet_lock       : freezes the bet register (low only while BETTING)
//   bet_refresh    : clears the bet register (high only in CLEAR)
//   round_active   : stake committed (LOCKED, SETTLE)
//   settled        : one-cycle pulse after balance takes its settled value
//   game_over      : balance exhausted, waiting for new_game
// Build option: BJ_NATURAL_PAYOUT_EN selects 3:2 natural blackjack payout.
// ---------------------------------------------------------------------------
module bankroll_ctrl
  import bj_pkg::*;
#(
  parameter int               BAL_W        = 10,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(500)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             deal,
  input  logic [BAL_W-1:0] bet,
  input  logic             outcome_valid,
  input  logic [1:0]       outcome,
  input  logic             new_game,
  output logic [BAL_W-1:0] balance,
  output logic             bet_lock,
  output logic             bet_refresh,
  output logic             round_active,
  output logic             settled,
  output logic             game_over
);

  state_t           state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] stake_q, stake_d;
  logic [1:0]       outcome_q, outcome_d;
  logic             settled_q, settled_d;

  logic             deal_ok;
  logic [BAL_W-1:0] settled_balance;

  // A deal only counts with a non-zero stake the player can cover.
  assign deal_ok = deal && (bet != '0) && (bet <= balance_q);

  payout_calc #(.BAL_W(BAL_W)) u_payout (
    .balance_i     (balance_q),
    .stake_i       (stake_q),
    .outcome_i     (outcome_q),
    .new_balance_o (settled_balance)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:   state_d = (balance_q != '0) ? ST_BETTING : ST_BROKE;
      ST_BETTING: if (deal_ok)       state_d = ST_LOCKED;
      ST_LOCKED:  if (outcome_valid) state_d = ST_SETTLE;
      ST_SETTLE:  state_d = ST_CLEAR;
      ST_BROKE:   if (new_game)      state_d = ST_CLEAR;
      default:    state_d = ST_CLEAR;
    endcase
  end

  // Moore outputs
  always_comb begin
    bet_lock     = 1'b1;
    bet_refresh  = 1'b0;
    round_active = 1'b0;
    game_over    = 1'b0;
    unique case (state_q)
      ST_CLEAR:   bet_refresh  = 1'b1;
      ST_BETTING: bet_lock     = 1'b0;
      ST_LOCKED:  round_active = 1'b1;
      ST_SETTLE:  round_active = 1'b1;
      ST_BROKE:   game_over    = 1'b1;
      default:    bet_lock     = 1'b1;
    endcase
  end

  // Balance / stake datapath
  always_comb begin
    balance_d = balance_q;
    stake_d   = stake_q;
    outcome_d = outcome_q;
    settled_d = 1'b0;
    unique case (state_q)
      ST_BETTING: begin
        if (deal_ok) begin
          stake_d   = bet;
          balance_d = balance_q - bet;
        end
      end
      ST_LOCKED: begin
        if (outcome_valid) outcome_d = outcome;
      end
      ST_SETTLE: begin
        balance_d = settled_balance;
        settled_d = 1'b1;
      end
      ST_BROKE: begin
        if (new_game) balance_d = INIT_BALANCE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // A hand interrupted by reset forfeits its stake.
      balance_q <= INIT_BALANCE;
      stake_q   <= '0;
      outcome_q <= OUT_LOSE;
      settled_q <= 1'b0;
    end else begin
      balance_q <= balance_d;
      stake_q   <= stake_d;
      outcome_q <= outcome_d;
      settled_q <= settled_d;
    end
  end

  assign balance = balance_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_bankroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bankroll_ctrl -- self-checking bench for bankroll_ctrl.
// A table of per-cycle vectors {inputs, expected state/balance/settled} is
// driven on the falling edge; the expected outputs are queued and compared
// one time unit after the following rising edge. A hand-written sequence then
// checks a bust-out with a bounded wait.
// ---------------------------------------------------------------------------
module tb_bankroll_ctrl;
  import bj_pkg::*;

  localparam int BAL_W = 10;

  logic             clk;
  logic             reset;
  logic             deal;
  logic [BAL_W-1:0] bet;
  logic             outcome_valid;
  logic [1:0]       outcome;
  logic             new_game;
  logic [BAL_W-1:0] balance;
  logic             bet_lock;
  logic             bet_refresh;
  logic             round_active;
  logic             settled;
  logic             game_over;

  bankroll_ctrl #(.BAL_W(BAL_W), .INIT_BALANCE(10'd500)) dut (
    .clk           (clk),
    .reset         (reset),
    .deal          (deal),
    .bet           (bet),
    .outcome_valid (outcome_valid),
    .outcome       (outcome),
    .new_game      (new_game),
    .balance       (balance),
    .bet_lock      (bet_lock),
    .bet_refresh   (bet_refresh),
    .round_active  (round_active),
    .settled       (settled),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             dl;
    logic [BAL_W-1:0] bt;
    logic             ov;
    logic [1:0]       oc;
    logic             ng;
    state_t           st;   // state expected after the edge
    logic [BAL_W-1:0] bal;
    logic             stl;
  } vec_t;

  typedef struct {
    logic [BAL_W-1:0] bal;
    logic             lock;
    logic             refr;
    logic             act;
    logic             stl;
    logic             go;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void v(input logic rst, input logic dl, input int bt,
                            input logic ov, input logic [1:0] oc, input logic ng,
                            input state_t st, input int bal, input logic stl);
    vec_t x;
    x.rst = rst; x.dl = dl; x.bt = BAL_W'(bt); x.ov = ov; x.oc = oc; x.ng = ng;
    x.st = st; x.bal = BAL_W'(bal); x.stl = stl;
    vecs.push_back(x);
  endfunction

  // Output decode of each state, as the controller is expected to present it.
  function automatic exp_t expect_of(input vec_t x);
    exp_t e;
    e.bal  = x.bal;
    e.stl  = x.stl;
    e.lock = (x.st != ST_BETTING);
    e.refr = (x.st == ST_CLEAR);
    e.act  = (x.st == ST_LOCKED) || (x.st == ST_SETTLE);
    e.go   = (x.st == ST_BROKE);
    return e;
  endfunction

  task automatic drive(input logic rst, input logic dl, input int bt,
                       input logic ov, input logic [1:0] oc, input logic ng);
    reset = rst; deal = dl; bet = BAL_W'(bt);
    outcome_valid = ov; outcome = oc; new_game = ng;
  endtask

`ifdef BJ_NATURAL_PAYOUT_EN
  localparam int BJ_BAL = 651;
`else
  localparam int BJ_BAL = 601;
`endif

  initial begin
    exp_t e;
    int   pulses;
    bit   seen;
    drive(1'b1, 1'b0, 0, 1'b0, OUT_LOSE, 1'b0);

    // ---- reset, refresh cycle, rejected deals, ignored outcome ----
    v(1,0,  0,0,OUT_LOSE,0, ST_CLEAR,  500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);
    v(0,1,  0,0,OUT_LOSE,0, ST_BETTING,500,0);   // zero bet
    v(0,1,600,0,OUT_LOSE,0, ST_BETTING,500,0);   // bet above balance
    v(0,0,  0,1,OUT_WIN ,0, ST_BETTING,500,0);   // outcome while betting
    // ---- bet 100, win ----
    v(0,1,100,0,OUT_LOSE,0, ST_LOCKED, 400,0);
    v(0,0,100,0,OUT_LOSE,0, ST_LOCKED, 400,0);
    v(0,1,100,0,OUT_LOSE,0, ST_LOCKED, 400,0);   // deal ignored in LOCKED
    v(0,0,100,1,OUT_WIN ,0, ST_SETTLE, 400,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,  600,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,600,0);
    // ---- reset, bet 101, natural blackjack ----
    v(1,0,  0,0,OUT_LOSE,0, ST_CLEAR,  500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);
    v(0,1,101,0,OUT_LOSE,0, ST_LOCKED, 399,0);
    v(0,0,101,1,OUT_BJ  ,0, ST_SETTLE, 399,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,  BJ_BAL,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,BJ_BAL,0);
    // ---- climb to 1000, then saturate ----
    v(1,0,  0,0,OUT_LOSE,0, ST_CLEAR,  500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);
    v(0,1,250,0,OUT_LOSE,0, ST_LOCKED, 250,0);
    v(0,0,  0,1,OUT_WIN ,0, ST_SETTLE, 250,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,  750,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,750,0);
    v(0,1,250,0,OUT_LOSE,0, ST_LOCKED, 500,0);
    v(0,0,  0,1,OUT_WIN ,0, ST_SETTLE, 500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR, 1000,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,1000,0);
    v(0,1,500,0,OUT_LOSE,0, ST_LOCKED, 500,0);
    v(0,0,  0,1,OUT_WIN ,0, ST_SETTLE, 500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,  int'(BAL_MAX),1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,int'(BAL_MAX),0);
    // ---- push with simultaneous deal in LOCKED ----
    v(0,1, 23,0,OUT_LOSE,0, ST_LOCKED,1000,0);
    v(0,1,  5,1,OUT_PUSH,0, ST_SETTLE,1000,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR, 1023,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,1023,0);
    // ---- simultaneous deal and outcome in BETTING: deal acts ----
    v(0,1, 50,1,OUT_WIN ,0, ST_LOCKED, 973,0);
    v(0,0,  0,1,OUT_LOSE,0, ST_SETTLE, 973,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,  973,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,973,0);
    // ---- bet everything, lose, bust out, new game ----
    v(0,1,973,0,OUT_LOSE,0, ST_LOCKED,   0,0);
    v(0,0,  0,1,OUT_LOSE,0, ST_SETTLE,   0,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_CLEAR,    0,1);
    v(0,0,  0,0,OUT_LOSE,0, ST_BROKE,    0,0);
    v(0,1,  5,1,OUT_WIN ,0, ST_BROKE,    0,0);   // ignored while broke
    v(0,0,  0,0,OUT_LOSE,1, ST_CLEAR,  500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);
    // ---- reset mid-hand forfeits the stake ----
    v(0,1,200,0,OUT_LOSE,0, ST_LOCKED, 300,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_LOCKED, 300,0);
    v(1,0,  0,1,OUT_WIN ,0, ST_CLEAR,  500,0);
    v(0,0,  0,0,OUT_LOSE,0, ST_BETTING,500,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].dl, int'(vecs[i].bt), vecs[i].ov, vecs[i].oc, vecs[i].ng);
      sb.push_back(expect_of(vecs[i]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d balance", i),      int'(balance),      int'(e.bal));
      check($sformatf("v%0d bet_lock", i),     int'(bet_lock),     int'(e.lock));
      check($sformatf("v%0d bet_refresh", i),  int'(bet_refresh),  int'(e.refr));
      check($sformatf("v%0d round_active", i), int'(round_active), int'(e.act));
      check($sformatf("v%0d settled", i),      int'(settled),      int'(e.stl));
      check($sformatf("v%0d game_over", i),    int'(game_over),    int'(e.go));
    end

    // ---- hand-written: bust-out with bounded wait, one settled pulse ----
    @(negedge clk);
    drive(1'b0, 1'b1, 500, 1'b0, OUT_LOSE, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b1, OUT_LOSE, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, OUT_LOSE, 1'b0);
    pulses = 0;
    seen   = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (settled) pulses++;
      if (game_over) seen = 1'b1;
    end
    check("bust game_over reached", int'(seen), 1);
    check("bust settled pulses", pulses, 1);
    check("bust balance", int'(balance), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, OUT_LOSE, 1'b1);
    @(posedge clk);
    #1;
    check("new_game balance", int'(balance), 500);
    check("new_game refresh", int'(bet_refresh), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, OUT_LOSE, 1'b0);
    @(posedge clk);
    #1;
    check("new_game betting", int'(bet_lock), 0);
    check("new_game game_over", int'(game_over), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
